// File: rtl/mod3_stream_ctrl_if.sv
// Byte stream in, mod-3 packet result out, as seen by mod3_stream_ctrl.
// slave = the controller, master = the packet source / result consumer.
interface mod3_stream_ctrl_if #(
  parameter int LEN_W = 5
);
  logic             s_valid;
  logic             s_ready;
  logic [7:0]       s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [1:0]       m_rem;
  logic             m_div3;
  logic [LEN_W-1:0] m_len;
  logic             m_ovf;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_rem, m_div3, m_len, m_ovf
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_rem, m_div3, m_len, m_ovf
  );
endinterface

// File: rtl/mod3_stream_ctrl.sv
// Folds one byte per cycle into a mod-3 accumulator and reports the packet remainder.
// Optional MOD3_STATS_EN adds saturating hand-off counters stat_pkts / stat_div.
module mod3_stream_ctrl #(
  parameter int MAX_BYTES = 16,
  parameter int LEN_W     = 5
) (
  input  logic                clk,
  input  logic                rst,
  mod3_stream_ctrl_if.slave   bus
`ifdef MOD3_STATS_EN
  ,
  output logic [15:0]         stat_pkts,
  output logic [15:0]         stat_div
`endif
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;

  state_e           state_q, state_d;
  logic [1:0]       acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:0]       rem_q, rem_d;
  logic             div3_q, div3_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [1:0]       byte_rem;
  logic [1:0]       sum_acc;
  logic [LEN_W-1:0] sum_cnt;
  logic             pkt_end;

  // 4 == 1 (mod 3), so the four 2-bit digits of a byte can simply be summed and refolded.
  function automatic logic [1:0] mod3_byte(input logic [7:0] b);
    logic [3:0] s;
    logic [2:0] f1;
    logic [1:0] f2;
    s  = 4'(b[7:6]) + 4'(b[5:4]) + 4'(b[3:2]) + 4'(b[1:0]);
    f1 = 3'(s[3:2]) + 3'(s[1:0]);
    f2 = 2'(f1[2]) + f1[1:0];
    return (f2 == 2'd3) ? 2'd0 : f2;
  endfunction

  function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  assign bus.s_ready = (state_q != HOLD) || bus.m_ready;
  assign bus.m_valid = (state_q == HOLD);
  assign bus.m_rem   = rem_q;
  assign bus.m_div3  = div3_q;
  assign bus.m_len   = len_q;
  assign bus.m_ovf   = ovf_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    div3_d   = div3_q;
    len_d    = len_q;
    ovf_d    = ovf_q;

    accept   = bus.s_valid && bus.s_ready;
    byte_rem = mod3_byte(bus.s_data);
    // Only an open packet contributes history; IDLE and HOLD start afresh.
    sum_acc  = mod3_add((state_q == ACCUM) ? acc_q : 2'd0, byte_rem);
    sum_cnt  = ((state_q == ACCUM) ? cnt_q : '0) + LEN_W'(1);
    pkt_end  = bus.s_last || (sum_cnt == LEN_W'(MAX_BYTES));

    if ((state_q == HOLD) && bus.m_ready) state_d = IDLE;

    if (accept) begin
      if (pkt_end) begin
        state_d = HOLD;
        rem_d   = sum_acc;
        div3_d  = (sum_acc == 2'd0);
        len_d   = sum_cnt;
        ovf_d   = !bus.s_last;
        acc_d   = 2'd0;
        cnt_d   = '0;
      end else begin
        state_d = ACCUM;
        acc_d   = sum_acc;
        cnt_d   = sum_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= 2'd0;
      cnt_q   <= '0;
      rem_q   <= 2'd0;
      div3_q  <= 1'b0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      div3_q  <= div3_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef MOD3_STATS_EN
  logic [15:0] stat_pkts_q;
  logic [15:0] stat_div_q;
  logic        handoff;

  assign handoff   = bus.m_valid && bus.m_ready;
  assign stat_pkts = stat_pkts_q;
  assign stat_div  = stat_div_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_pkts_q <= 16'd0;
      stat_div_q  <= 16'd0;
    end else begin
      if (handoff && (stat_pkts_q != 16'hFFFF)) stat_pkts_q <= stat_pkts_q + 16'd1;
      if (handoff && div3_q && (stat_div_q != 16'hFFFF)) stat_div_q <= stat_div_q + 16'd1;
    end
  end
`endif

endmodule
